// File: rtl/proc_pkg.sv
// ============================================================================
// proc_pkg : opcodes, controller states and field helpers for proc_control
// Revision : 1.0
// ============================================================================
`default_nettype none

package proc_pkg;

  localparam int OPC_W = 4;

  localparam logic [OPC_W-1:0] OP_LD  = 4'b0000;
  localparam logic [OPC_W-1:0] OP_MOV = 4'b0001;
  localparam logic [OPC_W-1:0] OP_ADD = 4'b0010;
  localparam logic [OPC_W-1:0] OP_SUB = 4'b0011;
  localparam logic [OPC_W-1:0] OP_INV = 4'b0100;
  localparam logic [OPC_W-1:0] OP_FLP = 4'b0101;
  localparam logic [OPC_W-1:0] OP_AND = 4'b0110;
  localparam logic [OPC_W-1:0] OP_OR  = 4'b0111;
  localparam logic [OPC_W-1:0] OP_XOR = 4'b1000;
  localparam logic [OPC_W-1:0] OP_LSL = 4'b1001;
  localparam logic [OPC_W-1:0] OP_LSR = 4'b1010;
  localparam logic [OPC_W-1:0] OP_ASR = 4'b1011;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    S1X  = 3'd1,
    S1   = 3'd2,
    S2   = 3'd3,
    S3   = 3'd4
  } state_t;

  function automatic logic op_is_binary(input logic [OPC_W-1:0] op);
    return op inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR};
  endfunction

  function automatic logic op_is_unary(input logic [OPC_W-1:0] op);
    return op inside {OP_INV, OP_FLP, OP_LSL, OP_LSR, OP_ASR};
  endfunction

  function automatic logic op_is_reserved(input logic [OPC_W-1:0] op);
    return op[3:2] == 2'b11;
  endfunction

endpackage

`default_nettype wire

// File: rtl/proc_control_if.sv
// ============================================================================
// proc_control_if : instruction request and datapath strobe bundle
// Revision        : 1.0
// ============================================================================
`default_nettype none

interface proc_control_if #(
  parameter int N = 10,
  parameter int R = 3
);
  logic            PEXEC;
  logic [N-1:0]    INSTR;
  logic [2**R-1:0] Rout;
  logic [2**R-1:0] Rin;
  logic            ENW;
  logic            Ain;
  logic            Gin;
  logic            Gout;
  logic [3:0]      FN;
  logic            BUSY;
  logic            DONE;
  logic            ERR;

  // master: instruction source / datapath side; slave: the controller
  modport master (
    output PEXEC, INSTR,
    input  Rout, Rin, ENW, Ain, Gin, Gout, FN, BUSY, DONE, ERR
  );

  modport slave (
    input  PEXEC, INSTR,
    output Rout, Rin, ENW, Ain, Gin, Gout, FN, BUSY, DONE, ERR
  );
endinterface

`default_nettype wire

// File: rtl/dec_onehot.sv
// ============================================================================
// dec_onehot : R-bit select plus enable to 2**R one-hot vector
// Revision   : 1.0
// ============================================================================
`default_nettype none

module dec_onehot #(
  parameter int R = 3
) (
  input  wire logic [R-1:0]    sel_i,
  input  wire logic            en_i,
  output logic      [2**R-1:0] onehot_o
);

  for (genvar i = 0; i < 2**R; i++) begin : g_bit
    assign onehot_o[i] = en_i && (sel_i == R'(i));
  end

endmodule

`default_nettype wire

// File: rtl/proc_control.sv
// ============================================================================
// proc_control : sequences bus/ALU strobes for one instruction per request
// Revision     : 1.0
// ============================================================================
`default_nettype none

module proc_control
  import proc_pkg::*;
#(
  parameter int N = 10,
  parameter int R = 3
) (
  input  wire logic     CLKb,
  input  wire logic     RST,
  proc_control_if.slave bus
);

  state_t       state_q, state_d;
  logic [N-1:0] ir_q, ir_d;

  logic [OPC_W-1:0] w_opc, w_new_op;
  logic [R-1:0]     w_rx, w_ry;
  logic [R-1:0]     w_rout_sel, w_rin_sel;
  logic             w_rout_en, w_rin_en;
  logic             w_enw, w_ain, w_gin, w_gout, w_done, w_err;

  assign w_opc    = ir_q[N-1 -: OPC_W];
  assign w_rx     = ir_q[2*R-1 -: R];
  assign w_ry     = ir_q[R-1:0];
  assign w_new_op = bus.INSTR[N-1 -: OPC_W];

  always_ff @(posedge CLKb) begin
    if (RST) begin
      state_q <= IDLE;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    ir_d       = ir_q;
    w_rout_en  = 1'b0;
    w_rout_sel = w_ry;
    w_rin_en   = 1'b0;
    w_rin_sel  = w_rx;
    w_enw      = 1'b0;
    w_ain      = 1'b0;
    w_gin      = 1'b0;
    w_gout     = 1'b0;
    w_done     = 1'b0;
    w_err      = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.PEXEC) begin
          ir_d = bus.INSTR;
          if (op_is_binary(w_new_op))     state_d = S1;
          else if (op_is_unary(w_new_op)) state_d = S2;
          else                            state_d = S1X;
        end
      end
      // single-cycle group: LD, MOV and reserved opcodes
      S1X: begin
        w_done  = 1'b1;
        state_d = IDLE;
        if (w_opc == OP_LD) begin
          w_enw    = 1'b1;
          w_rin_en = 1'b1;
        end else if (w_opc == OP_MOV) begin
          w_rout_en = 1'b1;
          w_rin_en  = 1'b1;
        end
        w_err = op_is_reserved(w_opc);
      end
      S1: begin
        w_rout_en  = 1'b1;
        w_rout_sel = w_rx;
        w_ain      = 1'b1;
        state_d    = S2;
      end
      S2: begin
        w_rout_en = 1'b1;
        w_gin     = 1'b1;
        state_d   = S3;
      end
      S3: begin
        w_gout   = 1'b1;
        w_rin_en = 1'b1;
        w_done   = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  dec_onehot #(.R(R)) u_dec_rout (
    .sel_i    (w_rout_sel),
    .en_i     (w_rout_en),
    .onehot_o (bus.Rout)
  );

  dec_onehot #(.R(R)) u_dec_rin (
    .sel_i    (w_rin_sel),
    .en_i     (w_rin_en),
    .onehot_o (bus.Rin)
  );

  assign bus.ENW  = w_enw;
  assign bus.Ain  = w_ain;
  assign bus.Gin  = w_gin;
  assign bus.Gout = w_gout;
  assign bus.DONE = w_done;
  assign bus.ERR  = w_err;
  assign bus.BUSY = (state_q != IDLE);
  assign bus.FN   = (state_q != IDLE) ? w_opc : 4'b0000;

endmodule

`default_nettype wire

// File: tb/tb_proc_control.sv
// ============================================================================
// tb_proc_control : table-driven scoreboard bench for proc_control
// Revision        : 1.0
// ============================================================================
`default_nettype none

module tb_proc_control;

  localparam int N = 10;
  localparam int R = 3;

  typedef struct packed {
    logic [7:0] rout;
    logic [7:0] rin;
    logic       enw;
    logic       ain;
    logic       gin;
    logic       gout;
    logic [3:0] fn;
    logic       busy;
    logic       done;
    logic       err;
  } out_t;

  typedef struct {
    string        name;
    logic [N-1:0] instr;
    int           len;
    out_t         exp [3];
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  proc_control_if #(.N(N), .R(R)) bus ();

  proc_control #(.N(N), .R(R)) dut (
    .CLKb (clk),
    .RST  (rst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  out_t  sb [$];
  string sb_name [$];
  int    checks = 0;
  int    errors = 0;
  vec_t  vecs [10];

  function automatic out_t o(input logic [7:0] rout, input logic [7:0] rin,
                             input logic enw, input logic ain, input logic gin,
                             input logic gout, input logic [3:0] fn,
                             input logic done, input logic err);
    out_t r;
    r = '{rout: rout, rin: rin, enw: enw, ain: ain, gin: gin, gout: gout,
          fn: fn, busy: 1'b1, done: done, err: err};
    return r;
  endfunction

  function automatic out_t actual();
    out_t a;
    a = '{rout: bus.Rout, rin: bus.Rin, enw: bus.ENW, ain: bus.Ain, gin: bus.Gin,
          gout: bus.Gout, fn: bus.FN, busy: bus.BUSY, done: bus.DONE, err: bus.ERR};
    return a;
  endfunction

  task automatic push(input string nm, input out_t e);
    sb.push_back(e);
    sb_name.push_back(nm);
  endtask

  task automatic check_cycle();
    out_t  a, e;
    string nm;
    @(negedge clk);
    a = actual();
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty got %h", a);
    end else begin
      e  = sb.pop_front();
      nm = sb_name.pop_front();
      if (a !== e) begin
        errors++;
        $display("FAIL %s got %h expected %h", nm, a, e);
      end
    end
    checks++;
    if ($countones({|a.rout, a.enw, a.gout}) > 1 || $countones(a.rin) > 1) begin
      errors++;
      $display("FAIL bus_exclusive rout=%h enw=%b gout=%b rin=%h expected at most one driver",
               a.rout, a.enw, a.gout, a.rin);
    end
  endtask

  task automatic set_vec(input int idx, input string nm, input logic [N-1:0] instr,
                         input int len, input out_t e0, input out_t e1, input out_t e2);
    vecs[idx].name   = nm;
    vecs[idx].instr  = instr;
    vecs[idx].len    = len;
    vecs[idx].exp[0] = e0;
    vecs[idx].exp[1] = e1;
    vecs[idx].exp[2] = e2;
  endtask

  // Request, accept, then scramble INSTR so late changes would show up.
  task automatic run_vec(input vec_t v);
    bus.PEXEC = 1'b1;
    bus.INSTR = v.instr;
    for (int k = 0; k < v.len; k++) push($sformatf("%s_c%0d", v.name, k + 1), v.exp[k]);
    push({v.name, "_idle"}, '0);
    @(posedge clk);
    #1;
    bus.PEXEC = 1'b0;
    bus.INSTR = ~v.instr;
    for (int k = 0; k <= v.len; k++) check_cycle();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    set_vec(0, "LD_R3",     10'b0000_011_000, 1,
            o(8'h00, 8'h08, 1, 0, 0, 0, 4'h0, 1, 0), '0, '0);
    set_vec(1, "MOV_R0_R7", 10'b0001_000_111, 1,
            o(8'h80, 8'h01, 0, 0, 0, 0, 4'h1, 1, 0), '0, '0);
    set_vec(2, "ADD_R1_R2", 10'b0010_001_010, 3,
            o(8'h02, 8'h00, 0, 1, 0, 0, 4'h2, 0, 0),
            o(8'h04, 8'h00, 0, 0, 1, 0, 4'h2, 0, 0),
            o(8'h00, 8'h02, 0, 0, 0, 1, 4'h2, 1, 0));
    set_vec(3, "SUB_R4_R4", 10'b0011_100_100, 3,
            o(8'h10, 8'h00, 0, 1, 0, 0, 4'h3, 0, 0),
            o(8'h10, 8'h00, 0, 0, 1, 0, 4'h3, 0, 0),
            o(8'h00, 8'h10, 0, 0, 0, 1, 4'h3, 1, 0));
    set_vec(4, "INV_R5_R6", 10'b0100_101_110, 2,
            o(8'h40, 8'h00, 0, 0, 1, 0, 4'h4, 0, 0),
            o(8'h00, 8'h20, 0, 0, 0, 1, 4'h4, 1, 0), '0);
    set_vec(5, "LSR_R2_R1", 10'b1010_010_001, 2,
            o(8'h02, 8'h00, 0, 0, 1, 0, 4'hA, 0, 0),
            o(8'h00, 8'h04, 0, 0, 0, 1, 4'hA, 1, 0), '0);
    set_vec(6, "XOR_R7_R0", 10'b1000_111_000, 3,
            o(8'h80, 8'h00, 0, 1, 0, 0, 4'h8, 0, 0),
            o(8'h01, 8'h00, 0, 0, 1, 0, 4'h8, 0, 0),
            o(8'h00, 8'h80, 0, 0, 0, 1, 4'h8, 1, 0));
    set_vec(7, "RSV_E",     10'b1110_000_000, 1,
            o(8'h00, 8'h00, 0, 0, 0, 0, 4'hE, 1, 1), '0, '0);
    set_vec(8, "RSV_F",     10'b1111_101_010, 1,
            o(8'h00, 8'h00, 0, 0, 0, 0, 4'hF, 1, 1), '0, '0);
    set_vec(9, "OR_R6_R3",  10'b0111_110_011, 3,
            o(8'h40, 8'h00, 0, 1, 0, 0, 4'h7, 0, 0),
            o(8'h08, 8'h00, 0, 0, 1, 0, 4'h7, 0, 0),
            o(8'h00, 8'h40, 0, 0, 0, 1, 4'h7, 1, 0));

    // Reset held two cycles while PEXEC requests an LD
    rst       = 1'b1;
    bus.PEXEC = 1'b1;
    bus.INSTR = vecs[0].instr;
    push("reset_cyc1", '0);
    push("reset_cyc2", '0);
    check_cycle();
    check_cycle();
    rst = 1'b0;
    run_vec(vecs[0]);

    for (int i = 0; i < 10; i++) run_vec(vecs[i]);

    // Reset during c2 of ADD abandons the write-back
    bus.PEXEC = 1'b1;
    bus.INSTR = vecs[2].instr;
    push("rstmid_c1", vecs[2].exp[0]);
    push("rstmid_c2", vecs[2].exp[1]);
    push("rstmid_c3", '0);
    push("rstmid_after", '0);
    @(posedge clk);
    #1;
    bus.PEXEC = 1'b0;
    check_cycle();
    check_cycle();
    rst = 1'b1;
    check_cycle();
    rst = 1'b0;
    check_cycle();

    // PEXEC held high across two MOVs: exactly one IDLE cycle between DONEs
    bus.PEXEC = 1'b1;
    bus.INSTR = 10'b0001_000_111;
    push("b2b_mov1", o(8'h80, 8'h01, 0, 0, 0, 0, 4'h1, 1, 0));
    push("b2b_gap",  '0);
    push("b2b_mov2", o(8'h01, 8'h80, 0, 0, 0, 0, 4'h1, 1, 0));
    push("b2b_idle", '0);
    @(posedge clk);
    #1;
    bus.INSTR = 10'b0001_111_000;
    check_cycle();
    check_cycle();
    @(posedge clk);
    #1;
    bus.PEXEC = 1'b0;
    check_cycle();
    check_cycle();

    run_vec(vecs[4]);

    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover got %0d entries expected 0", sb.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/proc_control.md
# proc_control

Sequencing controller for the bused multi-stage processor datapath. Accepts one instruction word per execute request, then drives the per-cycle control strobes that move operands over the shared bus into the ALU's A register, compute into G and write the result back to the register file. Replaces hand-driven Ain/Gin/Gout/FN stimulus. Sits between the instruction source and the ALU/register-file datapath.

## Interface
- N, default 10, instruction/datapath width; must equal 4 + 2*R
- R, default 3, register-select field width; register count = 2**R
- CLKb  input  1  clock, all state changes on rising edge
- RST  input  1  reset, synchronous, active-high
- PEXEC  input  1  execute request; sampled only in IDLE
- INSTR  input  N  instruction word: [N-1:N-4] opcode, [2R-1:R] Rx, [R-1:0] Ry
- Rout  output  2**R  one-hot register-to-bus enable
- Rin  output  2**R  one-hot bus-to-register write enable
- ENW  output  1  external data onto bus
- Ain  output  1  load ALU A register from bus
- Gin  output  1  load ALU G register
- Gout  output  1  G register onto bus
- FN  output  4  ALU function select
- BUSY  output  1  high in every non-IDLE state
- DONE  output  1  one-cycle pulse in final state of an instruction
- ERR  output  1  one-cycle pulse with DONE on reserved opcode

## Operation
- Opcodes: 0000 LD (Rx <= external bus), 0001 MOV (Rx <= Ry), 0010 ADD, 0011 SUB, 0110 AND, 0111 OR, 1000 XOR: binary, Rx <= Rx op Ry. 0100 INV, 0101 FLP, 1001 LSL, 1010 LSR, 1011 ASR: unary, Rx <= op(Ry). 1100-1111 reserved.
- IDLE: PEXEC=1 latches INSTR into internal ir register; next state by opcode: LD/MOV/reserved -> S1X, binary -> S1, unary -> S2.
- S1X: LD: ENW, Rin[Rx]. MOV: Rout[Ry], Rin[Rx]. Reserved: no Rin/Rout. All: DONE; reserved also ERR. -> IDLE.
- S1: Rout[Rx], Ain. -> S2.
- S2: Rout[Ry], Gin. -> S3.
- S3: Gout, Rin[Rx], DONE. -> IDLE.
- FN = ir opcode whenever BUSY; 0000 in IDLE.
- Outputs are Moore functions of state and ir; INSTR changes after acceptance have no effect.
- Bus exclusivity: at most one of {any Rout bit, ENW, Gout} high in any cycle; Rin at most one bit high.
- Rx == Ry legal (e.g., ADD R2,R2 doubles R2); no special case.

## Timing
- Reset: edge with RST=1 -> IDLE, ir = 0; all outputs 0 in following cycle. RST overrides PEXEC.
- Reset mid-instruction: no further strobes after the reset edge; in-flight write abandoned, no DONE.
- Acceptance at edge k: LD/MOV/reserved DONE in cycle k+1; unary in k+2; binary in k+3.
- PEXEC held high: next instruction accepted at the edge ending the first IDLE cycle after DONE; minimum one IDLE cycle between instructions.
- PEXEC ignored while BUSY.

## Structure
- Package proc_pkg: opcode localparams (shared with ALU, replacing its local constants), state enum {IDLE, S1X, S1, S2, S3}, field-extraction widths.
- Sub-module dec_onehot (parameter R): R-bit select + enable -> 2**R one-hot; two instances for Rout and Rin.
- Controller: state register, ir register, combinational output decode.

## Test plan
- RST=1 two cycles with PEXEC=1 -> all outputs 0, BUSY=0; after release, PEXEC=1 accepted next edge.
- LD R3, INSTR=10'b0000_011_000 -> next cycle ENW=1, Rin=8'b0000_1000, DONE=1; then IDLE.
- ADD R1,R2, INSTR=10'b0010_001_010 -> c1 Ain=1 Rout=8'b0000_0010; c2 Gin=1 FN=0010 Rout=8'b0000_0100; c3 Gout=1 Rin=8'b0000_0010 DONE=1.
- INV R5,R6, INSTR=10'b0100_101_110 -> c1 Gin=1 FN=0100 Rout=8'b0100_0000; c2 Gout=1 Rin=8'b0010_0000 DONE=1; Ain never high.
- Reserved INSTR=10'b1110_000_000 -> c1 DONE=1 ERR=1, Rin=Rout=0; RST during c2 of ADD -> c3 all zero, no Rin pulse.
- PEXEC held high, two MOV (10'b0001_000_111 then 10'b0001_111_000) -> DONE cycles separated by exactly one IDLE cycle; bus exclusivity asserted every cycle.
